// File: rtl/gray_counter.sv
// Up/down counter that registers both the binary count and its Gray encoding on the same edge.
// This suits it for CDC pointers and position encoders.
module gray_counter #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          SATURATE  = 1'b0,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             wrap,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH-1:0] ResetBin  = RESET_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ResetGray = ResetBin ^ (ResetBin >> 1);
  localparam logic [WIDTH-1:0] MaxVal    = '1;

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;

  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (load) begin
      bin_d = load_bin;
    end else if (en) begin
      if (up_dn) begin
        if (bin_q == MaxVal) begin
          // At a limit a step always flags wrap; saturation only suppresses the move.
          wrap_d = 1'b1;
          if (!SATURATE) bin_d = '0;
        end else begin
          bin_d = bin_q + 1'b1;
        end
      end else begin
        if (bin_q == '0) begin
          wrap_d = 1'b1;
          if (!SATURATE) bin_d = MaxVal;
        end else begin
          bin_d = bin_q - 1'b1;
        end
      end
    end
    // Encode the next value so gray_q tracks bin_q with no extra latency.
    gray_d = bin_d ^ (bin_d >> 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q  <= ResetBin;
      gray_q <= ResetGray;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin_out  = bin_q;
  assign gray_out = gray_q;
  assign wrap     = wrap_q;
  assign at_max   = (bin_q == MaxVal);
  assign at_min   = (bin_q == '0);

endmodule

// File: tb/tb_gray_counter.sv
// Directed vector table plus multi-cycle corner sequences and a random sweep against a reference
// model, across four parameterisations of gray_counter sharing one stimulus bus.
module tb_gray_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, up_dn, load;
  logic [7:0] ld;

  logic [3:0] a_bin, a_gray, s_bin, s_gray;
  logic [1:0] n_bin, n_gray;
  logic [7:0] w_bin, w_gray;
  logic       a_wrap, a_max, a_min, s_wrap, s_max, s_min;
  logic       n_wrap, n_max, n_min, w_wrap, w_max, w_min;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  gray_counter #(.WIDTH(4), .SATURATE(1'b0), .RESET_VAL(0)) u_a (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_bin(ld[3:0]),
    .bin_out(a_bin), .gray_out(a_gray), .wrap(a_wrap), .at_max(a_max), .at_min(a_min)
  );

  gray_counter #(.WIDTH(4), .SATURATE(1'b1), .RESET_VAL(3)) u_s (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_bin(ld[3:0]),
    .bin_out(s_bin), .gray_out(s_gray), .wrap(s_wrap), .at_max(s_max), .at_min(s_min)
  );

  gray_counter #(.WIDTH(2), .SATURATE(1'b0), .RESET_VAL(1)) u_n (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_bin(ld[1:0]),
    .bin_out(n_bin), .gray_out(n_gray), .wrap(n_wrap), .at_max(n_max), .at_min(n_min)
  );

  gray_counter #(.WIDTH(8), .SATURATE(1'b1), .RESET_VAL(0)) u_w (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_bin(ld),
    .bin_out(w_bin), .gray_out(w_gray), .wrap(w_wrap), .at_max(w_max), .at_min(w_min)
  );

  typedef struct {
    logic       en;
    logic       up;
    logic       ld;
    logic [3:0] lb;
    logic [3:0] bin;
    logic [3:0] gray;
    logic       wrap;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic e, input logic u, input logic l, input logic [7:0] b);
    @(negedge clk);
    en = e; up_dn = u; load = l; ld = b;
  endtask

  // Returns {wrap, next_bin} for a counter of width w.
  function automatic logic [32:0] model(input int w, input bit sat, input logic [31:0] b,
                                        input logic e, input logic u, input logic l,
                                        input logic [7:0] lb);
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    if (l) return {1'b0, 32'(lb) & mask};
    if (!e) return {1'b0, b};
    if (u) begin
      if (b == mask) return {1'b1, sat ? b : 32'd0};
      return {1'b0, b + 32'd1};
    end
    if (b == 32'd0) return {1'b1, sat ? b : mask};
    return {1'b0, b - 32'd1};
  endfunction

  task automatic chk_inst(input string nm, input int w, input logic [31:0] bin,
                          input logic [31:0] gray, input logic wr, input logic amax,
                          input logic amin, input logic [31:0] mb, input logic mw);
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    chk({nm, ".bin"}, bin, mb);
    chk({nm, ".gray"}, gray, mb ^ (mb >> 1));
    chk({nm, ".wrap"}, 32'(wr), 32'(mw));
    chk({nm, ".at_max"}, 32'(amax), 32'(mb == mask));
    chk({nm, ".at_min"}, 32'(amin), 32'(mb == 32'd0));
  endtask

  initial begin
    logic [3:0]  gseq[16];
    logic [3:0]  prev_gray, prev_bin;
    logic [31:0] ma, ms, mn, mw;
    logic [32:0] r;
    logic        wa, wsat, wn, ww;

    gseq = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
             4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
    for (int i = 0; i < 16; i++)
      tbl.push_back('{1'b1, 1'b1, 1'b0, 4'h0, 4'(i + 1), gseq[i], i == 15});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 4'h0, 4'hF, 4'h8, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 4'h0, 4'hE, 4'h9, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 4'h5, 4'h5, 4'h7, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 4'hA, 4'hA, 4'hF, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 4'h0, 4'hB, 4'hE, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 4'h0, 4'hB, 4'hE, 1'b0});

    rst = 1'b1; en = 1'b0; up_dn = 1'b0; load = 1'b0; ld = 8'h0;
    #2;
    chk("reset.a_bin", 32'(a_bin), 32'h0);
    chk("reset.a_gray", 32'(a_gray), 32'h0);
    chk("reset.a_wrap", 32'(a_wrap), 32'h0);
    chk("reset.a_min", 32'(a_min), 32'h1);
    chk("reset.s_bin", 32'(s_bin), 32'h3);
    chk("reset.s_gray", 32'(s_gray), 32'h2);
    chk("reset.n_bin", 32'(n_bin), 32'h1);
    @(negedge clk);
    rst = 1'b0;

    prev_gray = a_gray;
    prev_bin  = a_bin;
    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].up, tbl[i].ld, 8'(tbl[i].lb));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.bin", i), 32'(a_bin), 32'(tbl[i].bin));
      chk($sformatf("vec%0d.gray", i), 32'(a_gray), 32'(tbl[i].gray));
      chk($sformatf("vec%0d.wrap", i), 32'(a_wrap), 32'(tbl[i].wrap));
      chk($sformatf("vec%0d.at_max", i), 32'(a_max), 32'(tbl[i].bin == 4'hF));
      chk($sformatf("vec%0d.at_min", i), 32'(a_min), 32'(tbl[i].bin == 4'h0));
      if (tbl[i].en && !tbl[i].ld && tbl[i].bin != prev_bin)
        chk($sformatf("vec%0d.onebit", i), 32'($countones(a_gray ^ prev_gray)), 32'd1);
      prev_gray = a_gray;
      prev_bin  = a_bin;
    end

    // Saturating instance: blocked steps at max keep wrap high every cycle.
    drive(1'b0, 1'b0, 1'b1, 8'h0F);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 8'h00);
      @(posedge clk);
      #1;
      chk($sformatf("sat%0d.bin", i), 32'(s_bin), 32'hF);
      chk($sformatf("sat%0d.wrap", i), 32'(s_wrap), 32'h1);
      chk($sformatf("sat%0d.at_max", i), 32'(s_max), 32'h1);
    end
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    chk("sat_rev.bin", 32'(s_bin), 32'hE);
    chk("sat_rev.wrap", 32'(s_wrap), 32'h0);

    // Async reset between edges while counting from 9.
    drive(1'b0, 1'b0, 1'b1, 8'h09);
    @(posedge clk);
    #1;
    chk("arst_pre.bin", 32'(s_bin), 32'h9);
    en = 1'b1; up_dn = 1'b1; load = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst.bin", 32'(s_bin), 32'h3);
    chk("arst.gray", 32'(s_gray), 32'h2);
    chk("arst.wrap", 32'(s_wrap), 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("arst_step.bin", 32'(s_bin), 32'h4);
    chk("arst_step.gray", 32'(s_gray), 32'h6);

    // Random sweep: every instance tracked by the reference model from a fresh reset.
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    rst = 1'b1;
    #1 rst = 1'b0;
    ma = 32'd0; ms = 32'd3; mn = 32'd1; mw = 32'd0;
    for (int c = 0; c < 1000; c++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 9) == 0), 8'($urandom));
      r = model(4, 1'b0, ma, en, up_dn, load, ld); ma = r[31:0]; wa = r[32];
      r = model(4, 1'b1, ms, en, up_dn, load, ld); ms = r[31:0]; wsat = r[32];
      r = model(2, 1'b0, mn, en, up_dn, load, ld); mn = r[31:0]; wn = r[32];
      r = model(8, 1'b1, mw, en, up_dn, load, ld); mw = r[31:0]; ww = r[32];
      @(posedge clk);
      #1;
      chk_inst("rnd.w4", 4, 32'(a_bin), 32'(a_gray), a_wrap, a_max, a_min, ma, wa);
      chk_inst("rnd.w4s", 4, 32'(s_bin), 32'(s_gray), s_wrap, s_max, s_min, ms, wsat);
      chk_inst("rnd.w2", 2, 32'(n_bin), 32'(n_gray), n_wrap, n_max, n_min, mn, wn);
      chk_inst("rnd.w8s", 8, 32'(w_bin), 32'(w_gray), w_wrap, w_max, w_min, mw, ww);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
